// File: rtl/cpu_axi_pkg.sv
// rtl/cpu_axi_pkg.sv - shared FSM states and AXI constants for the CPU-to-AXI master bridge
package cpu_axi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_AW,
    S_W,
    S_B,
    S_DONE
  } state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_WORD  = 3'b010;
  localparam logic [3:0] LEN_SINGLE = 4'h0;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [3:0] WEB_NONE   = 4'hF;

endpackage

// File: rtl/cpu_axi_master.sv
// rtl/cpu_axi_master.sv - single-beat AXI master bridge for one CPU port (optional CPU_AXI_RESP_CHECK_EN)
module cpu_axi_master
  import cpu_axi_pkg::*;
#(
  parameter int ID_WIDTH  = 4,
  parameter int MASTER_ID = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_oe,
  input  logic [3:0]          req_web,
  input  logic [31:0]         req_addr,
  input  logic [31:0]         req_wdata,
  output logic [31:0]         rdata,
  output logic                stall,
  output logic                rdone,
  output logic                resp_err,
  output logic [ID_WIDTH-1:0] ARID_M,
  output logic [31:0]         ARADDR_M,
  output logic [3:0]          ARLEN_M,
  output logic [2:0]          ARSIZE_M,
  output logic [1:0]          ARBURST_M,
  output logic                ARVALID_M,
  input  logic                ARREADY_M,
  input  logic [ID_WIDTH-1:0] RID_M,
  input  logic [31:0]         RDATA_M,
  input  logic [1:0]          RRESP_M,
  input  logic                RLAST_M,
  input  logic                RVALID_M,
  output logic                RREADY_M,
  output logic [ID_WIDTH-1:0] AWID_M,
  output logic [31:0]         AWADDR_M,
  output logic [3:0]          AWLEN_M,
  output logic [2:0]          AWSIZE_M,
  output logic [1:0]          AWBURST_M,
  output logic                AWVALID_M,
  input  logic                AWREADY_M,
  output logic [31:0]         WDATA_M,
  output logic [3:0]          WSTRB_M,
  output logic                WLAST_M,
  output logic                WVALID_M,
  input  logic                WREADY_M,
  input  logic [ID_WIDTH-1:0] BID_M,
  input  logic [1:0]          BRESP_M,
  input  logic                BVALID_M,
  output logic                BREADY_M
);

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  strb_q;
  logic        wr_req;
  logic        any_req;

  assign wr_req  = (req_web != WEB_NONE);
  assign any_req = wr_req | req_oe;

  // CPU is held while a transaction is pending or a new one is being presented
  assign stall = ((state != S_IDLE) && (state != S_DONE)) || ((state == S_IDLE) && any_req);

  assign ARID_M    = ID_WIDTH'(MASTER_ID);
  assign ARADDR_M  = addr_q;
  assign ARLEN_M   = LEN_SINGLE;
  assign ARSIZE_M  = SIZE_WORD;
  assign ARBURST_M = BURST_INCR;
  assign AWID_M    = ID_WIDTH'(MASTER_ID);
  assign AWADDR_M  = addr_q;
  assign AWLEN_M   = LEN_SINGLE;
  assign AWSIZE_M  = SIZE_WORD;
  assign AWBURST_M = BURST_INCR;
  assign WDATA_M   = wdata_q;
  assign WSTRB_M   = strb_q;
  assign WLAST_M   = 1'b1;

  // Transaction FSM; VALID/READY/rdone are registered alongside the state they belong to
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      rdata     <= '0;
      rdone     <= 1'b0;
      ARVALID_M <= 1'b0;
      RREADY_M  <= 1'b0;
      AWVALID_M <= 1'b0;
      WVALID_M  <= 1'b0;
      BREADY_M  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (any_req) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            strb_q  <= ~req_web;
          end
          if (wr_req) begin
            state     <= S_AW;
            AWVALID_M <= 1'b1;
          end else if (req_oe) begin
            state     <= S_AR;
            ARVALID_M <= 1'b1;
          end
        end
        S_AR: begin
          if (ARREADY_M) begin
            state     <= S_R;
            ARVALID_M <= 1'b0;
            RREADY_M  <= 1'b1;
          end
        end
        S_R: begin
          if (RVALID_M) begin
            state    <= S_DONE;
            RREADY_M <= 1'b0;
            rdata    <= RDATA_M;
            rdone    <= 1'b1;
          end
        end
        S_AW: begin
          if (AWREADY_M) begin
            state     <= S_W;
            AWVALID_M <= 1'b0;
            WVALID_M  <= 1'b1;
          end
        end
        S_W: begin
          if (WREADY_M) begin
            state    <= S_B;
            WVALID_M <= 1'b0;
            BREADY_M <= 1'b1;
          end
        end
        S_B: begin
          if (BVALID_M) begin
            state    <= S_DONE;
            BREADY_M <= 1'b0;
            rdone    <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          rdone <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef CPU_AXI_RESP_CHECK_EN
  logic unused_inputs;
  assign unused_inputs = ^{RID_M, RLAST_M, BID_M};

  // Sticky error flag: any non-OKAY response on a completed R or B handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_err <= 1'b0;
    end else if (((state == S_R) && RVALID_M && (RRESP_M != RESP_OKAY)) ||
                 ((state == S_B) && BVALID_M && (BRESP_M != RESP_OKAY))) begin
      resp_err <= 1'b1;
    end
  end
`else
  logic unused_inputs;
  assign unused_inputs = ^{RID_M, RLAST_M, BID_M, RRESP_M, BRESP_M};
  assign resp_err = 1'b0;
`endif

endmodule
